// File: rtl/vga_pkg.sv
// Shared XGA 1024x768@60 timing constants and raster count type for the VGA
// pixel pipeline.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int HOR_PIXELS      = 1024;
  localparam int HOR_FRONT_PORCH = 24;
  localparam int HOR_SYNC_W      = 136;
  localparam int HOR_BACK_PORCH  = 160;

  localparam int VER_PIXELS      = 768;
  localparam int VER_FRONT_PORCH = 3;
  localparam int VER_SYNC_W      = 6;
  localparam int VER_BACK_PORCH  = 29;

  localparam int H_TOTAL = HOR_PIXELS + HOR_FRONT_PORCH + HOR_SYNC_W + HOR_BACK_PORCH;
  localparam int V_TOTAL = VER_PIXELS + VER_FRONT_PORCH + VER_SYNC_W + VER_BACK_PORCH;

  // Inclusive sync windows, in pixels / lines.
  localparam int HSYNC_START = HOR_PIXELS + HOR_FRONT_PORCH;
  localparam int HSYNC_END   = HSYNC_START + HOR_SYNC_W - 1;
  localparam int VSYNC_START = VER_PIXELS + VER_FRONT_PORCH;
  localparam int VSYNC_END   = VSYNC_START + VER_SYNC_W - 1;

endpackage

// File: rtl/vga_if_norgb.sv
// Raster position plus sync/blanking strobes, without pixel colour, as passed
// between the timing generator and the draw stages.
interface vga_if_norgb;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic hblnk;
  logic vsync;
  logic vblnk;

  modport master (output hcount, vcount, hsync, hblnk, vsync, vblnk);
  modport slave  (input  hcount, vcount, hsync, hblnk, vsync, vblnk);

endinterface

// File: rtl/vga_wrap_counter.sv
// Enabled modulo-(MAX+1) counter. Exposes the next value so the caller can
// register decode of it in the same cycle as the count itself.
module vga_wrap_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int MAX   = H_TOTAL - 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] count_nxt,
  output logic             carry
);

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX);

  always_comb begin
    carry     = en && (count == MAX_C);
    count_nxt = count;
    if (carry) begin
      count_nxt = '0;
    end else if (en) begin
      count_nxt = count + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster counters with registered sync/blank strobes and a
// one-cycle frame_start pulse on every wrap back to (0,0).
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = HOR_PIXELS,
  parameter int   H_FP     = HOR_FRONT_PORCH,
  parameter int   H_SYNC   = HOR_SYNC_W,
  parameter int   H_BP     = HOR_BACK_PORCH,
  parameter int   V_ACTIVE = VER_PIXELS,
  parameter int   V_FP     = VER_FRONT_PORCH,
  parameter int   V_SYNC   = VER_SYNC_W,
  parameter int   V_BP     = VER_BACK_PORCH,
  parameter logic SYNC_POL = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  vga_if_norgb.master out,
  output logic        frame_start
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_ACT_C    = CNT_W'(H_ACTIVE);
  localparam cnt_t HS_START_C = CNT_W'(H_ACTIVE + H_FP);
  localparam cnt_t HS_END_C   = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t V_ACT_C    = CNT_W'(V_ACTIVE);
  localparam cnt_t VS_START_C = CNT_W'(V_ACTIVE + V_FP);
  localparam cnt_t VS_END_C   = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  function automatic logic in_window(input cnt_t cnt, input cnt_t lo, input cnt_t hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

  function automatic logic sync_level(input logic active);
    return active ? SYNC_POL : ~SYNC_POL;
  endfunction

  cnt_t hcount_p0, vcount_p0;
  cnt_t hcount_p1, vcount_p1;
  logic h_carry, v_carry;
  logic hsync_p1, hblnk_p1, vsync_p1, vblnk_p1, frame_start_p1;

  // Stage p0: next raster position; the vertical counter steps on line wrap
  vga_wrap_counter #(.WIDTH(CNT_W), .MAX(H_TOT - 1)) u_hcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .count     (hcount_p1),
    .count_nxt (hcount_p0),
    .carry     (h_carry)
  );

  vga_wrap_counter #(.WIDTH(CNT_W), .MAX(V_TOT - 1)) u_vcnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (h_carry),
    .count     (vcount_p1),
    .count_nxt (vcount_p0),
    .carry     (v_carry)
  );

  // Stage p1: strobes decoded from the p0 position, registered alongside the counts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync_p1       <= ~SYNC_POL;
      vsync_p1       <= ~SYNC_POL;
      hblnk_p1       <= 1'b0;
      vblnk_p1       <= 1'b0;
      frame_start_p1 <= 1'b0;
    end else begin
      hsync_p1 <= sync_level(in_window(hcount_p0, HS_START_C, HS_END_C));
      vsync_p1 <= sync_level(in_window(vcount_p0, VS_START_C, VS_END_C));
      hblnk_p1 <= (hcount_p0 >= H_ACT_C);
      vblnk_p1 <= (vcount_p0 >= V_ACT_C);
      // A frozen raster keeps the pulse, so a stall right after a wrap still reports it
      if (en) begin
        frame_start_p1 <= v_carry;
      end
    end
  end

  assign out.hcount  = hcount_p1;
  assign out.vcount  = vcount_p1;
  assign out.hsync   = hsync_p1;
  assign out.hblnk   = hblnk_p1;
  assign out.vsync   = vsync_p1;
  assign out.vblnk   = vblnk_p1;
  assign frame_start = frame_start_p1;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size XGA instance for horizontal timing and
// a shrunken, inverted-polarity instance for vertical timing and frame wrap.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hs;
    logic        hb;
    logic        vs;
    logic        vb;
    logic        fs;
  } obs_t;

  typedef struct {
    int         sel;
    int         h;
    int         v;
    logic [3:0] exp;  // {hsync, hblnk, vsync, vblnk}
  } vec_t;

  logic clk;
  logic rst_n;
  logic en_a, en_b;
  logic fs_a, fs_b;

  int n_total;
  int n_bad;

  obs_t st_a, st_b;
  obs_t q_a[$];
  obs_t q_b[$];
  vec_t vecs[21];

  vga_if_norgb if_a ();
  vga_if_norgb if_b ();

  vga_timing_gen u_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_a),
    .out         (if_a),
    .frame_start (fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2),
    .SYNC_POL (1'b0)
  ) u_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en_b),
    .out         (if_b),
    .frame_start (fs_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int htot(input int sel);
    return (sel == 0) ? 1344 : 16;
  endfunction

  function automatic int vtot(input int sel);
    return (sel == 0) ? 806 : 11;
  endfunction

  function automatic obs_t decode(input int sel, input int h, input int v, input logic fs);
    int ha, hf, hsw, va, vf, vsw;
    logic pol;
    obs_t o;
    if (sel == 0) begin
      ha = 1024; hf = 24; hsw = 136; va = 768; vf = 3; vsw = 6; pol = 1'b1;
    end else begin
      ha = 8; hf = 2; hsw = 3; va = 6; vf = 1; vsw = 2; pol = 1'b0;
    end
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hb = (h >= ha);
    o.vb = (v >= va);
    o.hs = ((h >= ha + hf) && (h < ha + hf + hsw)) ? pol : ~pol;
    o.vs = ((v >= va + vf) && (v < va + vf + vsw)) ? pol : ~pol;
    o.fs = fs;
    return o;
  endfunction

  function automatic obs_t reset_obs(input int sel);
    return decode(sel, 0, 0, 1'b0);
  endfunction

  function automatic obs_t next_obs(input int sel, input obs_t cur, input logic e);
    int h, v;
    if (!e) return cur;
    h = int'(cur.h);
    v = int'(cur.v);
    if (h == htot(sel) - 1) begin
      h = 0;
      v = (v == vtot(sel) - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
    return decode(sel, h, v, (h == 0) && (v == 0));
  endfunction

  function automatic obs_t act(input int sel);
    if (sel == 0)
      return {if_a.hcount, if_a.vcount, if_a.hsync, if_a.hblnk, if_a.vsync, if_a.vblnk, fs_a};
    return {if_b.hcount, if_b.vcount, if_b.hsync, if_b.hblnk, if_b.vsync, if_b.vblnk, fs_b};
  endfunction

  task automatic check_obs(input string name, input obs_t a, input obs_t e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b, want h=%0d v=%0d hs=%b hb=%b vs=%b vb=%b fs=%b",
               name, a.h, a.v, a.hs, a.hb, a.vs, a.vb, a.fs,
               e.h, e.v, e.hs, e.hb, e.vs, e.vb, e.fs);
    end
  endtask

  task automatic check_int(input string name, input int a, input int e);
    n_total++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", name, a, e);
    end
  endtask

  // One clock: the model advances on the same edge as the DUTs, outputs are compared mid-cycle.
  task automatic tick();
    obs_t e;
    @(posedge clk);
    if (rst_n) begin
      st_a = next_obs(0, st_a, en_a);
      q_a.push_back(st_a);
      st_b = next_obs(1, st_b, en_b);
      q_b.push_back(st_b);
    end
    @(negedge clk);
    while (q_a.size() > 0) begin
      e = q_a.pop_front();
      check_obs("sb_a", act(0), e);
    end
    while (q_b.size() > 0) begin
      e = q_b.pop_front();
      check_obs("sb_b", act(1), e);
    end
  endtask

  task automatic wait_pos(input int sel, input int h, input int v, input int bound);
    int n;
    obs_t o;
    n = 0;
    o = act(sel);
    while (!((int'(o.h) == h) && (int'(o.v) == v)) && (n < bound)) begin
      tick();
      n++;
      o = act(sel);
    end
    n_total++;
    if ((int'(o.h) != h) || (int'(o.v) != v)) begin
      n_bad++;
      $display("FAIL reach_%0d_%0d_%0d: got (%0d,%0d), want (%0d,%0d)", sel, h, v, o.h, o.v, h, v);
    end
  endtask

  initial begin
    obs_t o;
    int n;

    n_total = 0;
    n_bad   = 0;

    vecs[0]  = '{0, 1023, 0, 4'b0000};
    vecs[1]  = '{0, 1024, 0, 4'b0100};
    vecs[2]  = '{0, 1047, 0, 4'b0100};
    vecs[3]  = '{0, 1048, 0, 4'b1100};
    vecs[4]  = '{0, 1183, 0, 4'b1100};
    vecs[5]  = '{0, 1184, 0, 4'b0100};
    vecs[6]  = '{0, 1343, 0, 4'b0100};
    vecs[7]  = '{0, 0,    1, 4'b0000};
    vecs[8]  = '{0, 5,    1, 4'b0000};
    vecs[9]  = '{1, 7,    0, 4'b1010};
    vecs[10] = '{1, 8,    0, 4'b1110};
    vecs[11] = '{1, 9,    0, 4'b1110};
    vecs[12] = '{1, 10,   0, 4'b0110};
    vecs[13] = '{1, 12,   0, 4'b0110};
    vecs[14] = '{1, 13,   0, 4'b1110};
    vecs[15] = '{1, 15,   5, 4'b1110};
    vecs[16] = '{1, 0,    6, 4'b1011};
    vecs[17] = '{1, 0,    7, 4'b1001};
    vecs[18] = '{1, 11,   8, 4'b0101};
    vecs[19] = '{1, 0,    9, 4'b1011};
    vecs[20] = '{1, 15,  10, 4'b1111};

    rst_n = 1'b0;
    en_a  = 1'b0;
    en_b  = 1'b0;
    st_a  = reset_obs(0);
    st_b  = reset_obs(1);
    repeat (3) tick();
    rst_n = 1'b1;
    check_obs("reset_a", act(0), reset_obs(0));
    check_obs("reset_b", act(1), reset_obs(1));

    // Reset asserted between clock edges must clear outputs without waiting for a clock
    en_a = 1'b1;
    repeat (6) tick();
    #3;
    rst_n = 1'b0;
    st_a  = reset_obs(0);
    st_b  = reset_obs(1);
    q_a.delete();
    q_b.delete();
    #1;
    check_obs("rst_async_a", act(0), reset_obs(0));
    check_obs("rst_async_b", act(1), reset_obs(1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      wait_pos(vecs[i].sel, vecs[i].h, vecs[i].v, 3000);
      o = act(vecs[i].sel);
      check_int($sformatf("vec%0d", i), int'({o.hs, o.hb, o.vs, o.vb}), int'(vecs[i].exp));
    end

    // Freeze on the last hsync pixel, then resume into the back porch
    wait_pos(0, 1183, 1, 3000);
    en_a = 1'b0;
    repeat (10) tick();
    o = act(0);
    check_int("frz_h", int'(o.h), 1183);
    check_int("frz_hs", int'(o.hs), 1);
    en_a = 1'b1;
    tick();
    o = act(0);
    check_int("resume_h", int'(o.h), 1184);
    check_int("resume_hs", int'(o.hs), 0);
    en_a = 1'b0;

    en_b = 1'b1;
    for (int i = 9; i < 21; i++) begin
      wait_pos(vecs[i].sel, vecs[i].h, vecs[i].v, 400);
      o = act(vecs[i].sel);
      check_int($sformatf("vec%0d", i), int'({o.hs, o.hb, o.vs, o.vb}), int'(vecs[i].exp));
    end

    // Frame wrap, held pulse while frozen, and frame period
    wait_pos(1, 15, 10, 400);
    tick();
    o = act(1);
    check_int("wrap_h", int'(o.h), 0);
    check_int("wrap_v", int'(o.v), 0);
    check_int("wrap_fs", int'(o.fs), 1);
    en_b = 1'b0;
    repeat (3) tick();
    o = act(1);
    check_int("fs_hold", int'(o.fs), 1);
    en_b = 1'b1;
    tick();
    o = act(1);
    check_int("fs_drop", int'(o.fs), 0);
    check_int("fs_drop_h", int'(o.h), 1);

    n = 0;
    o = act(1);
    while (!o.fs && (n < 400)) begin
      tick();
      n++;
      o = act(1);
    end
    check_int("to_wrap", n, 175);
    n = 0;
    do begin
      tick();
      n++;
      o = act(1);
    end while (!o.fs && (n < 400));
    check_int("frame_period", n, 16 * 11);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
